popcount_stream_accum: RTL and testbench
========================================

// Module: popcount_stream_accum
// PURPOSE
//  Streaming population-count engine, successor to the fixed 8-bit combinational popcount.
//  Accepts DATA_W-bit words over a valid/ready handshake and counts ones (or zeros) per word
//  through a registered adder tree. Sums per-word counts over a frame terminated by in_last,
//  then holds the frame total on a valid/ready output. Sits between the io_in pin wrapper and
//  downstream result logic.
// PARAMETERS
//  DATA_W   8    input word width; any value >= 2
//  ACC_W    16   frame accumulator / out_count width; must be > $clog2(DATA_W+1)
// PORTS
//  clk        in   1       single clock; all state on rising edge
//  rst_n      in   1       asynchronous, active-low reset
//  mode_zero  in   1       0: count ones, 1: count zeros; sampled with each accepted word
//  in_valid   in   1       input word valid
//  in_ready   out  1       block can accept a word this cycle
//  in_data    in   DATA_W  input word
//  in_last    in   1       accepted word is the last of its frame
//  out_valid  out  1       frame result valid; held until accepted
//  out_ready  in   1       downstream accepts the result
//  out_count  out  ACC_W   frame total (saturated)
//  out_sat    out  1       frame total saturated at 2**ACC_W-1
// BEHAVIOUR
//  Reset: in_ready=1, out_valid=0, out_count=0, out_sat=0; accumulator, pipeline valids and FSM cleared.
//  Accept: word accepted when in_valid & in_ready. Word popcount = popcount(mode_zero ? ~in_data : in_data),
//   width CW=$clog2(DATA_W+1), zero-extended to ACC_W before summing.
//  Pipeline: accepted cycle t -> tree result registered t+1 -> accumulator updated t+2.
//  FSM states:
//   ACCUM: in_ready=1. Accepting a word with in_last=1 -> DRAIN.
//   DRAIN: in_ready=0; wait until last word's count has entered the accumulator (2 cycles) -> HOLD.
//   HOLD : out_valid=1, out_count/out_sat stable. out_valid & out_ready -> ACCUM; accumulator and
//          sat flag clear in that same cycle; in_ready=1 again from the next cycle.
//  Latency: out_valid rises 3 cycles after the cycle the in_last word is accepted.
//  Single-word frame (first accepted word has in_last=1) is legal; same latency.
//  Saturation: if acc + word_count > 2**ACC_W-1, acc := 2**ACC_W-1 and sat set; sticky until frame consumed.
//  in_valid=0 bubbles in ACCUM insert nothing; accumulator unchanged. in_data/in_last ignored while in_ready=0.
//  out_ready with out_valid=0 has no effect. Throughput: one word per cycle inside a frame;
//   inter-frame gap = DRAIN + HOLD cycles (>=3).
//  Reset mid-frame or mid-HOLD: all partial state discarded; no result emitted for that frame.
// STRUCTURE
//  popcount_pkg: function cnt_w(DATA_W)=$clog2(DATA_W+1); enum state_t {ACCUM, DRAIN, HOLD};
//   localparam ZERO_MODE=1'b1.
//  Sub-module popcount_tree #(DATA_W): balanced binary adder tree, each level widening by 1 bit,
//   registered output with valid; instantiated once. Accumulator, saturation and FSM in top level.
// TESTING
//  1. Reset, 1-word frame 8'hFF mode_zero=0 in_last=1 -> out_valid 3 cycles later, out_count=8, out_sat=0.
//  2. Frame 8'h0F,8'hAA,8'h01(last), mode_zero=1 -> out_count=4+4+7=15; in_ready=0 until result taken.
//  3. Hold out_ready=0 for 10 cycles in HOLD -> out_valid, out_count stable, in_ready=0; then accept ->
//     next frame starts at 0.
//  4. ACC_W=4, frame of 3x8'hFF -> out_count=4'hF, out_sat=1; next frame 8'h03 -> 2, out_sat=0.
//  5. Bubbles: 8'h01, idle 5 cycles, 8'h01(last) -> out_count=2.
//  6. Assert rst_n low for 1 cycle mid-frame after 2 words -> no out_valid; next 1-word frame 8'h07 -> 3.
//  Random: DATA_W in {2,8,13,32}, random valid/ready, scoreboard vs reference model.

Source files
------------

// File: rtl/popcount_pkg.sv
// Shared types and helpers for the streaming popcount engine.
package popcount_pkg;

    localparam logic ZERO_MODE = 1'b1;

    typedef enum logic [1:0] {
        ACCUM,
        DRAIN,
        HOLD
    } state_t;

    function automatic int cnt_w(input int dataW);
        return $clog2(dataW + 1);
    endfunction

endpackage

// File: rtl/popcount_tree.sv
// Balanced binary adder tree counting the set bits of one word, with a registered result and valid.
module popcount_tree
    import popcount_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CW     = cnt_w(DATA_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    output logic [CW-1:0]     count_o
);

    localparam int LVL = $clog2(DATA_W);
    localparam int N2  = 1 << LVL;

    logic          valid_q;
    logic [CW-1:0] count_q;

    // Leaves are padded to a power of two; every level adds pairs and grows by one bit.
    for (genvar k = 0; k <= LVL; k++) begin : g_lvl
        logic [k:0] sum [N2 >> k];
        if (k == 0) begin : g_leaf
            for (genvar i = 0; i < N2; i++) begin : g_bit
                if (i < DATA_W) begin : g_in
                    assign sum[i] = data_i[i];
                end else begin : g_pad
                    assign sum[i] = 1'b0;
                end
            end
        end else begin : g_add
            for (genvar i = 0; i < (N2 >> k); i++) begin : g_node
                assign sum[i] = {1'b0, g_lvl[k-1].sum[2*i]} + {1'b0, g_lvl[k-1].sum[2*i+1]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            count_q <= '0;
        end else begin
            valid_q <= valid_i;
            count_q <= g_lvl[LVL].sum[0][CW-1:0];
        end
    end

    assign valid_o = valid_q;
    assign count_o = count_q;

endmodule

// File: rtl/popcount_stream_accum.sv
// Streaming popcount: per-word counts from the tree are summed over a frame and held until taken.
module popcount_stream_accum
    import popcount_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mode_zero_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic              in_last_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [ACC_W-1:0]  out_count_o,
    output logic              out_sat_o
);

    localparam int               CW      = cnt_w(DATA_W);
    localparam logic [ACC_W:0]   ACC_MAX = {1'b0, {ACC_W{1'b1}}};

    state_t             state_q;
    logic               inReady_q;
    logic               outValid_q;
    logic               drainCnt_q;
    logic [ACC_W-1:0]   acc_q;
    logic [ACC_W-1:0]   acc_d;
    logic               sat_q;
    logic               sat_d;

    logic               accept;
    logic               frameDone;
    logic [DATA_W-1:0]  treeData;
    logic               treeValid;
    logic [CW-1:0]      treeCount;
    logic [ACC_W:0]     accSum;

    assign accept    = in_valid_i & inReady_q;
    assign frameDone = outValid_q & out_ready_i;
    assign treeData  = (mode_zero_i == ZERO_MODE) ? ~in_data_i : in_data_i;

    popcount_tree #(
        .DATA_W (DATA_W)
    ) u_tree (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid_i (accept),
        .data_i  (treeData),
        .valid_o (treeValid),
        .count_o (treeCount)
    );

    // One extra bit of headroom lets the overflow test happen before clamping.
    assign accSum = {1'b0, acc_q} + (ACC_W+1)'(treeCount);

    always_comb begin
        acc_d = acc_q;
        sat_d = sat_q;
        if (frameDone) begin
            acc_d = '0;
            sat_d = 1'b0;
        end else if (treeValid) begin
            if (accSum > ACC_MAX) begin
                acc_d = ACC_MAX[ACC_W-1:0];
                sat_d = 1'b1;
            end else begin
                acc_d = accSum[ACC_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            sat_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            sat_q <= sat_d;
        end
    end

    // DRAIN covers the tree register and the accumulator update of the last word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ACCUM;
            inReady_q  <= 1'b1;
            outValid_q <= 1'b0;
            drainCnt_q <= 1'b0;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (accept && in_last_i) begin
                        state_q    <= DRAIN;
                        inReady_q  <= 1'b0;
                        drainCnt_q <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (drainCnt_q) begin
                        state_q    <= HOLD;
                        outValid_q <= 1'b1;
                    end else begin
                        drainCnt_q <= 1'b1;
                    end
                end
                HOLD: begin
                    if (out_ready_i) begin
                        state_q    <= ACCUM;
                        outValid_q <= 1'b0;
                        inReady_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= ACCUM;
                    inReady_q  <= 1'b1;
                    outValid_q <= 1'b0;
                    drainCnt_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready_o  = inReady_q;
    assign out_valid_o = outValid_q;
    assign out_count_o = acc_q;
    assign out_sat_o   = sat_q;

endmodule

// File: tb/tb_popcount_stream_accum.sv
// Bench driving five popcount_stream_accum instances of different widths in lockstep.
module tb_popcount_stream_accum;

    logic        clk;
    logic        rst_n;
    logic        mode;
    logic        inValid;
    logic        inLast;
    logic        outReady;
    logic [31:0] inData;

    logic        inReady8, outValid8, sat8;
    logic [15:0] cnt8;
    logic        ready4, valid4, sat4;
    logic [3:0]  cnt4;
    logic        readyR2, validR2, satR2;
    logic [7:0]  cntR2;
    logic        readyR13, validR13, satR13;
    logic [7:0]  cntR13;
    logic        readyR32, validR32, satR32;
    logic [7:0]  cntR32;

    typedef struct packed {
        logic [4:0][15:0] cnt;
        logic [4:0]       sat;
    } exp_t;

    localparam int WID  [5] = '{8, 8, 2, 13, 32};
    localparam int MAXV [5] = '{65535, 15, 255, 255, 255};

    exp_t             expQ [$];
    exp_t             monExp;
    int               accM [5];
    bit               satM [5];
    logic [4:0][15:0] obsCnt;
    logic [4:0]       obsSat;
    int               assertCount = 0;
    int               failCount   = 0;

    popcount_stream_accum #(.DATA_W(8), .ACC_W(16)) u8 (
        .clk(clk), .rst_n(rst_n), .mode_zero_i(mode), .in_valid_i(inValid),
        .in_ready_o(inReady8), .in_data_i(inData[7:0]), .in_last_i(inLast),
        .out_valid_o(outValid8), .out_ready_i(outReady), .out_count_o(cnt8), .out_sat_o(sat8));

    popcount_stream_accum #(.DATA_W(8), .ACC_W(4)) u4 (
        .clk(clk), .rst_n(rst_n), .mode_zero_i(mode), .in_valid_i(inValid),
        .in_ready_o(ready4), .in_data_i(inData[7:0]), .in_last_i(inLast),
        .out_valid_o(valid4), .out_ready_i(outReady), .out_count_o(cnt4), .out_sat_o(sat4));

    popcount_stream_accum #(.DATA_W(2), .ACC_W(8)) uR2 (
        .clk(clk), .rst_n(rst_n), .mode_zero_i(mode), .in_valid_i(inValid),
        .in_ready_o(readyR2), .in_data_i(inData[1:0]), .in_last_i(inLast),
        .out_valid_o(validR2), .out_ready_i(outReady), .out_count_o(cntR2), .out_sat_o(satR2));

    popcount_stream_accum #(.DATA_W(13), .ACC_W(8)) uR13 (
        .clk(clk), .rst_n(rst_n), .mode_zero_i(mode), .in_valid_i(inValid),
        .in_ready_o(readyR13), .in_data_i(inData[12:0]), .in_last_i(inLast),
        .out_valid_o(validR13), .out_ready_i(outReady), .out_count_o(cntR13), .out_sat_o(satR13));

    popcount_stream_accum #(.DATA_W(32), .ACC_W(8)) uR32 (
        .clk(clk), .rst_n(rst_n), .mode_zero_i(mode), .in_valid_i(inValid),
        .in_ready_o(readyR32), .in_data_i(inData), .in_last_i(inLast),
        .out_valid_o(validR32), .out_ready_i(outReady), .out_count_o(cntR32), .out_sat_o(satR32));

    assign obsCnt[0] = cnt8;
    assign obsCnt[1] = 16'(cnt4);
    assign obsCnt[2] = 16'(cntR2);
    assign obsCnt[3] = 16'(cntR13);
    assign obsCnt[4] = 16'(cntR32);
    assign obsSat    = {satR32, satR13, satR2, sat4, sat8};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed no end of test, expected finish before 500000");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic int pc(input logic [31:0] d, input int w, input bit mz);
        int n = 0;
        for (int i = 0; i < w; i++) begin
            if (d[i] != mz) n++;
        end
        return n;
    endfunction

    // Reference model and scoreboard: words are scored when offered while ready is high,
    // frame totals are pushed on the last word and popped when the result handshake happens.
    always @(negedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 5; i++) begin
                accM[i] = 0;
                satM[i] = 1'b0;
            end
        end else begin
            checkOutput("lockstep", {readyR32, readyR13, readyR2, ready4, validR32, validR13, validR2, valid4},
                        {{4{inReady8}}, {4{outValid8}}});
            if (outValid8 && outReady) begin
                checkOutput("pendingFrame", 32'(expQ.size() > 0), 1);
                if (expQ.size() > 0) begin
                    monExp = expQ.pop_front();
                    for (int i = 0; i < 5; i++) begin
                        checkOutput($sformatf("sbCount%0d", i), obsCnt[i], monExp.cnt[i]);
                        checkOutput($sformatf("sbSat%0d", i), obsSat[i], monExp.sat[i]);
                    end
                end
            end
            if (inValid && inReady8) begin
                for (int i = 0; i < 5; i++) begin
                    accM[i] = accM[i] + pc(inData, WID[i], mode);
                    if (accM[i] > MAXV[i]) begin
                        accM[i] = MAXV[i];
                        satM[i] = 1'b1;
                    end
                end
                if (inLast) begin
                    for (int i = 0; i < 5; i++) begin
                        monExp.cnt[i] = 16'(accM[i]);
                        monExp.sat[i] = satM[i];
                        accM[i] = 0;
                        satM[i] = 1'b0;
                    end
                    expQ.push_back(monExp);
                end
            end
        end
    end

    task automatic applyStimulus(input logic [31:0] d, input bit last, input bit mz);
        bit ok = 1'b0;
        inData  = d;
        inLast  = last;
        mode    = mz;
        inValid = 1'b1;
        for (int c = 0; c < 50 && !ok; c++) begin
            @(negedge clk);
            ok = inReady8;
        end
        checkOutput("acceptReady", 32'(ok), 1);
        @(posedge clk);
        #1;
        inValid = 1'b0;
        inLast  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic takeResult(input int e8, input bit s8, input int e4, input bit s4);
        bit seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            seen = outValid8;
        end
        checkOutput("resultValid", 32'(seen), 1);
        checkOutput("count8", 32'(cnt8), e8);
        checkOutput("sat8", 32'(sat8), 32'(s8));
        checkOutput("count4", 32'(cnt4), e4);
        checkOutput("sat4", 32'(sat4), 32'(s4));
        @(posedge clk);
        #1;
        outReady = 1'b1;
        @(posedge clk);
        #1;
        outReady = 1'b0;
        @(negedge clk);
        checkOutput("readyAfterTake", 32'(inReady8), 1);
        checkOutput("validAfterTake", 32'(outValid8), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n    = 1'b0;
        mode     = 1'b0;
        inValid  = 1'b0;
        inLast   = 1'b0;
        outReady = 1'b0;
        inData   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rstReady", 32'(inReady8), 1);
        checkOutput("rstValid", 32'(outValid8), 0);
        checkOutput("rstCount", 32'(cnt8), 0);
        checkOutput("rstSat", 32'(sat8), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(1);

        $display("[TB] single-word frame and latency");
        applyStimulus(32'h0000_00FF, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("lat1Valid", 32'(outValid8), 0);
        @(negedge clk);
        checkOutput("lat2Valid", 32'(outValid8), 0);
        @(negedge clk);
        checkOutput("lat3Valid", 32'(outValid8), 1);
        @(posedge clk);
        #1;
        takeResult(8, 1'b0, 8, 1'b0);

        $display("[TB] zero-count frame held for ten cycles");
        applyStimulus(32'h0000_000F, 1'b0, 1'b1);
        applyStimulus(32'h0000_00AA, 1'b0, 1'b1);
        applyStimulus(32'h0000_0001, 1'b1, 1'b1);
        inValid = 1'b1;
        inLast  = 1'b1;
        inData  = 32'hFFFF_FFFF;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            checkOutput("holdReady", 32'(inReady8), 0);
            if (c >= 2) begin
                checkOutput("holdValid", 32'(outValid8), 1);
                checkOutput("holdCount", 32'(cnt8), 15);
            end
        end
        @(posedge clk);
        #1;
        inValid = 1'b0;
        inLast  = 1'b0;
        takeResult(15, 1'b0, 15, 1'b0);
        applyStimulus(32'h0000_0001, 1'b1, 1'b0);
        takeResult(1, 1'b0, 1, 1'b0);

        $display("[TB] saturation");
        applyStimulus(32'h0000_00FF, 1'b0, 1'b0);
        applyStimulus(32'h0000_00FF, 1'b0, 1'b0);
        applyStimulus(32'h0000_00FF, 1'b1, 1'b0);
        takeResult(24, 1'b0, 15, 1'b1);
        applyStimulus(32'h0000_0003, 1'b1, 1'b0);
        takeResult(2, 1'b0, 2, 1'b0);

        $display("[TB] bubbles");
        applyStimulus(32'h0000_0001, 1'b0, 1'b0);
        idle(5);
        applyStimulus(32'h0000_0001, 1'b1, 1'b0);
        takeResult(2, 1'b0, 2, 1'b0);

        $display("[TB] reset mid-frame");
        applyStimulus(32'h0000_00FF, 1'b0, 1'b0);
        applyStimulus(32'h0000_00FF, 1'b0, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("midRstCount", 32'(cnt8), 0);
        checkOutput("midRstReady", 32'(inReady8), 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checkOutput("postRstValid", 32'(outValid8), 0);
        end
        @(posedge clk);
        #1;
        applyStimulus(32'h0000_0007, 1'b1, 1'b0);
        takeResult(3, 1'b0, 3, 1'b0);

        $display("[TB] random frames");
        for (int f = 0; f < 40; f++) begin
            int n;
            bit hs;
            n  = $urandom_range(1, 10);
            hs = 1'b0;
            for (int w = 0; w < n; w++) begin
                inData = $urandom;
                idle($urandom_range(0, 2));
                applyStimulus($urandom, (w == n - 1), 1'($urandom_range(0, 1)));
            end
            for (int c = 0; c < 60 && !hs; c++) begin
                outReady = 1'($urandom_range(0, 1));
                inValid  = 1'($urandom_range(0, 1));
                inLast   = 1'($urandom_range(0, 1));
                inData   = $urandom;
                @(negedge clk);
                hs = outValid8 && outReady;
                @(posedge clk);
                #1;
            end
            outReady = 1'b0;
            inValid  = 1'b0;
            inLast   = 1'b0;
            checkOutput("frameDrained", 32'(hs), 1);
        end
        idle(2);
        checkOutput("queueEmpty", expQ.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
